vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator: pixel/line counters, HSYNC/VSYNC/ACTIVE, line/frame strobes.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_delay_line.sv | 34 +++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constant sets and small elaboration helpers for the raster
// timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fporch;
        int unsigned h_pulse;
        int unsigned h_bporch;
        int unsigned v_active;
        int unsigned v_fporch;
        int unsigned v_pulse;
        int unsigned v_bporch;
    } vga_timing_t;

    localparam vga_timing_t VGA_1600x1200_60 = '{
        h_active: 1600, h_fporch: 64, h_pulse: 192, h_bporch: 304,
        v_active: 1200, v_fporch: 1,  v_pulse: 3,   v_bporch: 46
    };

    localparam vga_timing_t VGA_1024x768_60 = '{
        h_active: 1024, h_fporch: 24, h_pulse: 136, h_bporch: 160,
        v_active: 768,  v_fporch: 3,  v_pulse: 6,   v_bporch: 29
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// CE-qualified shift register with synchronous reset value; DEPTH=0 collapses
// to a wire so callers can parametrise latency down to nothing.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, ce};
        assign dout        = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stages [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
            end else if (ce) begin
                stages[0] <= din;
                for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
            end
        end

        assign dout = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync and active decode with
// configurable output lag, and undelayed line/frame strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_1600x1200_60.h_active,
    parameter int H_FPORCH = VGA_1600x1200_60.h_fporch,
    parameter int H_PULSE  = VGA_1600x1200_60.h_pulse,
    parameter int H_BPORCH = VGA_1600x1200_60.h_bporch,
    parameter int V_ACTIVE = VGA_1600x1200_60.v_active,
    parameter int V_FPORCH = VGA_1600x1200_60.v_fporch,
    parameter int V_PULSE  = VGA_1600x1200_60.v_pulse,
    parameter int V_BPORCH = VGA_1600x1200_60.v_bporch,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    parameter int DELAY    = 0,
    parameter int CW       = 13
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          ACTIVE,
    output logic          LINE_START,
    output logic          FRAME_START,
    output logic [CW-1:0] h,
    output logic [CW-1:0] v
);

    localparam int H_TOTAL = H_ACTIVE + H_FPORCH + H_PULSE + H_BPORCH;
    localparam int V_TOTAL = V_ACTIVE + V_FPORCH + V_PULSE + V_BPORCH;

    if ((64'd1 << CW) <= 64'(max_u(H_TOTAL, V_TOTAL))) begin : g_cw_check
        $error("vga_timing_gen: CW too narrow for the configured totals");
    end
    if (DELAY < 0 || DELAY > 15) begin : g_delay_check
        $error("vga_timing_gen: DELAY must be within 0..15");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FPORCH);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FPORCH + H_PULSE - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FPORCH);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FPORCH + V_PULSE - 1);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          line_start_q;
    logic          frame_start_q;
    // Bit order {hs, vs, act}, all in asserted-high sense; polarity is applied at the pins.
    logic [2:0]    raw;
    logic [2:0]    raw_q;
    logic [2:0]    raw_d;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_comb begin
        raw    = 3'b000;
        raw[2] = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        raw[1] = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        raw[0] = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            raw_q         <= 3'b000;
        end else begin
            line_start_q  <= CE && h_last;
            frame_start_q <= CE && h_last && v_last;
            if (CE) begin
                raw_q <= raw;
                h_cnt <= h_last ? '0 : h_cnt + 1'b1;
                if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end
        end
    end

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (DELAY),
        .RESET_VAL (3'b000)
    ) u_delay (
        .clk  (CLK),
        .rst  (RST),
        .ce   (CE),
        .din  (raw_q),
        .dout (raw_d)
    );

    assign HSYNC       = raw_d[2] ? H_POL : ~H_POL;
    assign VSYNC       = raw_d[1] ? V_POL : ~V_POL;
    assign ACTIVE      = raw_d[0];
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;
    assign h           = h_cnt;
    assign v           = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 16x8 raster: three instances (plain, DELAY=4,
// inverted polarity) checked every cycle against a pixel-count reference model.
module tb_vga_timing_gen;

    localparam int CW = 8;
    localparam int HT = 16;
    localparam int VT = 8;
    localparam int VW = 2 * CW + 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic CE  = 1'b0;

    always #5 CLK = ~CLK;

    logic [CW-1:0] h_a, v_a, h_b, v_b, h_c, v_c;
    logic hs_a, vs_a, act_a, ls_a, fs_a;
    logic hs_b, vs_b, act_b, ls_b, fs_b;
    logic hs_c, vs_c, act_c, ls_c, fs_c;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FPORCH(2), .H_PULSE(3), .H_BPORCH(3),
        .V_ACTIVE(4), .V_FPORCH(1), .V_PULSE(2), .V_BPORCH(1),
        .H_POL(1'b1), .V_POL(1'b1), .DELAY(0), .CW(CW)
    ) dut_a (
        .CLK(CLK), .RST(RST), .CE(CE), .HSYNC(hs_a), .VSYNC(vs_a), .ACTIVE(act_a),
        .LINE_START(ls_a), .FRAME_START(fs_a), .h(h_a), .v(v_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FPORCH(2), .H_PULSE(3), .H_BPORCH(3),
        .V_ACTIVE(4), .V_FPORCH(1), .V_PULSE(2), .V_BPORCH(1),
        .H_POL(1'b1), .V_POL(1'b1), .DELAY(4), .CW(CW)
    ) dut_b (
        .CLK(CLK), .RST(RST), .CE(CE), .HSYNC(hs_b), .VSYNC(vs_b), .ACTIVE(act_b),
        .LINE_START(ls_b), .FRAME_START(fs_b), .h(h_b), .v(v_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FPORCH(2), .H_PULSE(3), .H_BPORCH(3),
        .V_ACTIVE(4), .V_FPORCH(1), .V_PULSE(2), .V_BPORCH(1),
        .H_POL(1'b0), .V_POL(1'b0), .DELAY(0), .CW(CW)
    ) dut_c (
        .CLK(CLK), .RST(RST), .CE(CE), .HSYNC(hs_c), .VSYNC(vs_c), .ACTIVE(act_c),
        .LINE_START(ls_c), .FRAME_START(fs_c), .h(h_c), .v(v_c)
    );

    logic [3*VW-1:0] obs_all;
    assign obs_all = {h_a, v_a, hs_a, vs_a, act_a, ls_a, fs_a,
                      h_b, v_b, hs_b, vs_b, act_b, ls_b, fs_b,
                      h_c, v_c, hs_c, vs_c, act_c, ls_c, fs_c};

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    // Model state: pixels advanced since the last reset, and whether the last edge advanced.
    int n           = 0;
    bit adv         = 1'b0;

    // {hs, vs, act} for the p-th pixel after reset; nothing shown before pixel 0.
    function automatic logic [2:0] raw_at(input int p);
        int hh, vv;
        if (p < 0) return 3'b000;
        hh = p % HT;
        vv = (p / HT) % VT;
        return {(hh >= 10 && hh <= 12), (vv >= 5 && vv <= 6), (hh < 8 && vv < 4)};
    endfunction

    function automatic logic [VW-1:0] exp_vec(input int d, input bit hp, input bit vp);
        logic [2:0] r;
        r = raw_at(n - 1 - d);
        return {CW'(n % HT), CW'((n / HT) % VT),
                r[2] ? hp : ~hp, r[1] ? vp : ~vp, r[0],
                adv && (n % HT == 0), adv && (n % (HT * VT) == 0)};
    endfunction

    function automatic logic [3*VW-1:0] exp_all();
        return {exp_vec(0, 1'b1, 1'b1), exp_vec(4, 1'b1, 1'b1), exp_vec(0, 1'b0, 1'b0)};
    endfunction

    task automatic tick(input logic rst_i, input logic ce_i);
        RST = rst_i;
        CE  = ce_i;
        @(posedge CLK);
        cyc++;
        if (rst_i) begin
            n   = 0;
            adv = 1'b0;
        end else if (ce_i) begin
            n++;
            adv = 1'b1;
        end else begin
            adv = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            if (obs_all !== exp_all()) begin
                miscompares++;
                $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all());
            end
            vectors++;
            if ({h_a, v_a, hs_a, vs_a, act_a, ls_a, fs_a, hs_c, vs_c} !== {CW'(0), CW'(0), 7'b0000011}) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b hs_n=%b vs_n=%b exp 0 0 0 0 0 0 0 1 1",
                         cyc, h_a, v_a, hs_a, vs_a, act_a, ls_a, fs_a, hs_c, vs_c);
            end
            vectors++;
        end
        tick(1'b0, 1'b1);
        if (h_a !== CW'(1)) begin
            miscompares++;
            $display("FAIL reset_release_h got=%0d exp=1", h_a);
        end
        vectors++;
    endtask

    task automatic test_continuous();
        int ls_cnt, fs_cnt, hs_cnt, act_cnt;
        ls_cnt = 0; fs_cnt = 0; hs_cnt = 0; act_cnt = 0;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 2 * HT * VT; i++) begin
            tick(1'b0, 1'b1);
            if (obs_all !== exp_all()) begin
                miscompares++;
                $display("FAIL continuous cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all());
            end
            vectors++;
            ls_cnt  += int'(ls_a);
            fs_cnt  += int'(fs_a);
            hs_cnt  += int'(hs_a);
            act_cnt += int'(act_a);
        end
        if ({ls_cnt, fs_cnt, hs_cnt, act_cnt} !== {32'd16, 32'd2, 32'd48, 32'd64}) begin
            miscompares++;
            $display("FAIL continuous_counts got ls=%0d fs=%0d hs=%0d act=%0d exp ls=16 fs=2 hs=48 act=64",
                     ls_cnt, fs_cnt, hs_cnt, act_cnt);
        end
        vectors++;
    endtask

    task automatic test_ce_alternate();
        int ls_cnt, hs_cnt, ls_prev, gap;
        ls_cnt = 0; hs_cnt = 0; ls_prev = -1; gap = 0;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 4 * HT; i++) begin
            tick(1'b0, (i % 2) == 0);
            if (obs_all !== exp_all()) begin
                miscompares++;
                $display("FAIL ce_alternate cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all());
            end
            vectors++;
            hs_cnt += int'(hs_a);
            if (ls_a) begin
                ls_cnt++;
                if (ls_prev >= 0) gap = i - ls_prev;
                ls_prev = i;
            end
        end
        if ({ls_cnt, hs_cnt, gap} !== {32'd2, 32'd12, 32'd32}) begin
            miscompares++;
            $display("FAIL ce_alternate_counts got ls=%0d hs=%0d line=%0d exp ls=2 hs=12 line=32",
                     ls_cnt, hs_cnt, gap);
        end
        vectors++;
    endtask

    task automatic test_random_ce();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 600; i++) begin
            tick(1'b0, $urandom_range(0, 3) != 0);
            if (obs_all !== exp_all()) begin
                miscompares++;
                $display("FAIL random_ce cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all());
            end
            vectors++;
        end
    endtask

    task automatic test_delay();
        int rise_a, rise_b;
        rise_a = -1; rise_b = -1;
        tick(1'b1, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 1'b1);
            if (obs_all !== exp_all()) begin
                miscompares++;
                $display("FAIL delay cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all());
            end
            vectors++;
            if (hs_a && rise_a < 0) rise_a = i;
            if (hs_b && rise_b < 0) rise_b = i;
        end
        if (rise_a !== 11 || rise_b !== 15) begin
            miscompares++;
            $display("FAIL delay_hsync_rise got a=%0d b=%0d exp a=11 b=15", rise_a, rise_b);
        end
        vectors++;
    endtask

    task automatic test_polarity();
        int hs_low, vs_low;
        hs_low = 0; vs_low = 0;
        tick(1'b1, 1'b0);
        for (int i = 0; i < HT * VT; i++) begin
            tick(1'b0, 1'b1);
            if (obs_all !== exp_all()) begin
                miscompares++;
                $display("FAIL polarity cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all());
            end
            vectors++;
            hs_low += int'(!hs_c);
            vs_low += int'(!vs_c);
        end
        if (hs_low !== 24 || vs_low !== 32) begin
            miscompares++;
            $display("FAIL polarity_counts got hs_low=%0d vs_low=%0d exp hs_low=24 vs_low=32", hs_low, vs_low);
        end
        vectors++;
    endtask

    task automatic test_mid_reset();
        int wait_cnt;
        bit seen;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3 * HT + 5; i++) tick(1'b0, 1'b1);
        if ({h_a, v_a, act_a, act_b} !== {CW'(5), CW'(3), 2'b11}) begin
            miscompares++;
            $display("FAIL mid_reset_pre got h=%0d v=%0d act=%b act_d4=%b exp h=5 v=3 act=1 act_d4=1",
                     h_a, v_a, act_a, act_b);
        end
        vectors++;
        tick(1'b1, 1'b1);
        if ({h_a, v_a, act_a, act_b, hs_b, vs_b} !== {CW'(0), CW'(0), 4'b0000}) begin
            miscompares++;
            $display("FAIL mid_reset_post got h=%0d v=%0d act=%b act_d4=%b hs_d4=%b vs_d4=%b exp all 0",
                     h_a, v_a, act_a, act_b, hs_b, vs_b);
        end
        vectors++;
        wait_cnt = 0;
        seen     = 1'b0;
        while (!seen && wait_cnt < 200) begin
            tick(1'b0, 1'b1);
            wait_cnt++;
            if (obs_all !== exp_all()) begin
                miscompares++;
                $display("FAIL mid_reset_run cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all());
            end
            vectors++;
            seen = fs_a;
        end
        if (!seen || wait_cnt != HT * VT) begin
            miscompares++;
            $display("FAIL mid_reset_frame_gap got seen=%0d after=%0d exp seen=1 after=128", seen, wait_cnt);
        end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_ce_alternate();
        test_random_ce();
        test_delay();
        test_polarity();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
